// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : midi_pkg
//  Purpose  : Shared MIDI constants and state encodings for the note receiver.
//             Holds the status-byte constants, the reset pitch, and the
//             receiver/parser state types.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package midi_pkg;

    // Status byte constants (channel nibble zero)
    localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;
    localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
    localparam logic [7:0] MIDI_SYSTEM   = 8'hF0;
    localparam logic [7:0] MIDI_REALTIME = 8'hF8;

    // Pitch presented after reset: A4
    localparam logic [7:0] NOTE_RESET = 8'd69;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        PS_WAIT  = 2'd0,
        PS_DATA1 = 2'd1,
        PS_DATA2 = 2'd2,
        PS_SKIP  = 2'd3
    } parser_state_e;

    typedef enum logic [1:0] {
        RS_NONE     = 2'd0,
        RS_NOTE_ON  = 2'd1,
        RS_NOTE_OFF = 2'd2
    } run_status_e;

    // Real-time bytes may appear anywhere and never disturb message parsing
    function automatic logic is_realtime(input logic [7:0] b);
        return (b >= MIDI_REALTIME);
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : midi_uart_rx
//  Purpose  : 8N1 serial byte receiver for the MIDI line.
//  Ports    : clk_i       system clock (rising edge)
//             nrst_i      asynchronous active-low reset
//             rx_i        asynchronous serial line, idle high
//             data_o      last good byte received
//             valid_o     one-cycle strobe, cycle after a good stop sample
//             frameErr_o  one-cycle pulse when the stop bit reads low
//  Revision : 1.0  initial release
// ============================================================================
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int F_CLK_HZ = 10_000_000,
    parameter int BAUD     = 31_250
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frameErr_o
);

    localparam int DIV   = F_CLK_HZ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    rx_state_e        state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;
    logic [7:0]       shift_q,    shift_d;
    logic [7:0]       data_q,     data_d;
    logic             valid_q,    valid_d;
    logic             ferr_q,     ferr_d;
    // Set after a low stop bit; holds the receiver until the line is idle
    logic             stop_err_q, stop_err_d;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            stop_err_q <= stop_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        stop_err_d = stop_err_q;

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    // Start-bit midpoint: a high line here was only a glitch
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (stop_err_q) begin
                    if (rx_sync_q) begin
                        stop_err_d = 1'b0;
                        state_d    = RX_IDLE;
                    end
                end else if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d     = 1'b1;
                        stop_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign frameErr_o = ferr_q;

endmodule
`default_nettype wire

// File: rtl/midi_note_rx.sv
`default_nettype none
// ============================================================================
//  Module   : midi_note_rx
//  Purpose  : Monophonic MIDI Note On/Off decoder for one channel, with
//             running status and last-note priority.
//  Ports    : clk_i       system clock (rising edge)
//             nrst_i      asynchronous active-low reset
//             rx_i        asynchronous MIDI serial line, idle high
//             note_o      current note number (bit 7 always 0)
//             velocity_o  velocity of the last accepted Note On
//             gate_o      high while the current note is held
//             phaseRst_o  one-cycle pulse per accepted Note On
//             frameErr_o  one-cycle pulse per byte with a low stop bit
//  Revision : 1.0  initial release
// ============================================================================
module midi_note_rx
    import midi_pkg::*;
#(
    parameter int         F_CLK_HZ = 10_000_000,
    parameter int         BAUD     = 31_250,
    parameter logic [3:0] CHANNEL  = 4'd0
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       rx_i,
    output logic [7:0] note_o,
    output logic [6:0] velocity_o,
    output logic       gate_o,
    output logic       phaseRst_o,
    output logic       frameErr_o
);

    logic [7:0] rx_byte;
    logic       rx_valid;

    midi_uart_rx #(
        .F_CLK_HZ (F_CLK_HZ),
        .BAUD     (BAUD)
    ) u_uart_rx (
        .clk_i      (clk_i),
        .nrst_i     (nrst_i),
        .rx_i       (rx_i),
        .data_o     (rx_byte),
        .valid_o    (rx_valid),
        .frameErr_o (frameErr_o)
    );

    parser_state_e pstate_q,    pstate_d;
    run_status_e   rs_q,        rs_d;
    logic [6:0]    pend_q,      pend_d;
    logic [7:0]    note_q,      note_d;
    logic [6:0]    vel_q,       vel_d;
    logic          gate_q,      gate_d;
    logic          phase_rst_q, phase_rst_d;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            pstate_q    <= PS_WAIT;
            rs_q        <= RS_NONE;
            pend_q      <= 7'd0;
            note_q      <= NOTE_RESET;
            vel_q       <= 7'd0;
            gate_q      <= 1'b0;
            phase_rst_q <= 1'b0;
        end else begin
            pstate_q    <= pstate_d;
            rs_q        <= rs_d;
            pend_q      <= pend_d;
            note_q      <= note_d;
            vel_q       <= vel_d;
            gate_q      <= gate_d;
            phase_rst_q <= phase_rst_d;
        end
    end

    logic ch_match;
    assign ch_match = (rx_byte[3:0] == CHANNEL);

    always_comb begin
        pstate_d    = pstate_q;
        rs_d        = rs_q;
        pend_d      = pend_q;
        note_d      = note_q;
        vel_d       = vel_q;
        gate_d      = gate_q;
        phase_rst_d = 1'b0;

        if (rx_valid && !is_realtime(rx_byte)) begin
            if (rx_byte >= MIDI_SYSTEM) begin
                rs_d     = RS_NONE;
                pstate_d = PS_WAIT;
            end else if (rx_byte[7]) begin
                if (ch_match && rx_byte[7:4] == MIDI_NOTE_ON[7:4]) begin
                    rs_d     = RS_NOTE_ON;
                    pstate_d = PS_DATA1;
                end else if (ch_match && rx_byte[7:4] == MIDI_NOTE_OFF[7:4]) begin
                    rs_d     = RS_NOTE_OFF;
                    pstate_d = PS_DATA1;
                end else begin
                    rs_d     = RS_NONE;
                    pstate_d = PS_SKIP;
                end
            end else begin
                case (pstate_q)
                    PS_WAIT: begin
                        if (rs_q != RS_NONE) begin
                            pend_d   = rx_byte[6:0];
                            pstate_d = PS_DATA2;
                        end
                    end
                    PS_DATA1: begin
                        pend_d   = rx_byte[6:0];
                        pstate_d = PS_DATA2;
                    end
                    PS_DATA2: begin
                        // Message complete; stay armed for running status
                        pstate_d = PS_DATA1;
                        if (rs_q == RS_NOTE_ON && rx_byte[6:0] != 7'd0) begin
                            note_d      = {1'b0, pend_q};
                            vel_d       = rx_byte[6:0];
                            gate_d      = 1'b1;
                            phase_rst_d = 1'b1;
                        end else if ({1'b0, pend_q} == note_q) begin
                            // Releasing an older note leaves the held one alone
                            gate_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign note_o     = note_q;
    assign velocity_o = vel_q;
    assign gate_o     = gate_q;
    assign phaseRst_o = phase_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_note_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_midi_note_rx
//  Purpose  : Self-checking bench for midi_note_rx. Serial frames are driven
//             bit by bit; a byte-level message model predicts note, velocity
//             and gate, which are compared every cycle outside the short
//             window where a frame is completing. Pulse outputs are counted
//             per frame and compared against the model's prediction.
//  Revision : 1.0  initial release
// ============================================================================
module tb_midi_note_rx;

    localparam int         F_CLK_HZ = 10_000_000;
    localparam int         BAUD     = 31_250;
    localparam int         DIV      = F_CLK_HZ / BAUD;
    localparam logic [3:0] CHANNEL  = 4'd0;

    logic       clk_i  = 1'b0;
    logic       nrst_i = 1'b0;
    logic       rx_i   = 1'b1;
    logic [7:0] note_o;
    logic [6:0] velocity_o;
    logic       gate_o;
    logic       phaseRst_o;
    logic       frameErr_o;

    midi_note_rx #(
        .F_CLK_HZ (F_CLK_HZ),
        .BAUD     (BAUD),
        .CHANNEL  (CHANNEL)
    ) dut (
        .clk_i      (clk_i),
        .nrst_i     (nrst_i),
        .rx_i       (rx_i),
        .note_o     (note_o),
        .velocity_o (velocity_o),
        .gate_o     (gate_o),
        .phaseRst_o (phaseRst_o),
        .frameErr_o (frameErr_o)
    );

    always #50 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int n_phase  = 0;
    int n_ferr   = 0;
    bit settling = 1'b1;

    // Message-level model
    logic [7:0] m_note;
    logic [6:0] m_vel;
    logic       m_gate;
    logic [6:0] m_pend;
    int         m_rs;        // 0 none, 9 note on, 8 note off
    bit         m_have_pend;

    task automatic model_reset();
        m_note      = 8'd69;
        m_vel       = 7'd0;
        m_gate      = 1'b0;
        m_pend      = 7'd0;
        m_rs        = 0;
        m_have_pend = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, output int exp_pulse);
        exp_pulse = 0;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            m_rs = 0;
            m_have_pend = 1'b0;
            return;
        end
        if (b[7]) begin
            m_have_pend = 1'b0;
            if (b[3:0] == CHANNEL && (b[7:4] == 4'h9 || b[7:4] == 4'h8))
                m_rs = int'(b[7:4]);
            else
                m_rs = 0;
            return;
        end
        if (m_rs == 0) return;
        if (!m_have_pend) begin
            m_pend = b[6:0];
            m_have_pend = 1'b1;
            return;
        end
        m_have_pend = 1'b0;
        if (m_rs == 9 && b != 8'd0) begin
            m_note = {1'b0, m_pend};
            m_vel = b[6:0];
            m_gate = 1'b1;
            exp_pulse = 1;
        end else if ({1'b0, m_pend} == m_note) begin
            m_gate = 1'b0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // One clock of simulation, sampled on the falling edge
    task automatic step();
        @(negedge clk_i);
        if (phaseRst_o) n_phase++;
        if (frameErr_o) n_ferr++;
        if (!settling) begin
            n_checks++;
            if ({note_o, velocity_o, gate_o} === {m_note, m_vel, m_gate}) n_pass++;
            else $display("FAIL outputs_vs_model t=%0t: got note=%02h vel=%02h gate=%0b, required note=%02h vel=%02h gate=%0b",
                          $time, note_o, velocity_o, gate_o, m_note, m_vel, m_gate);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        int p0, f0, ep;
        p0 = n_phase;
        f0 = n_ferr;
        repeat ($urandom_range(0, 15)) step();
        rx_i = 1'b0;
        repeat (DIV) step();
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (DIV) step();
        end
        settling = 1'b1;
        if (stop_ok) begin
            rx_i = 1'b1;
            repeat (DIV / 2 + 32) step();
            model_byte(b, ep);
        end else begin
            rx_i = 1'b0;
            repeat (DIV) step();
            rx_i = 1'b1;
            repeat (32) step();
            ep = 0;
        end
        check("phaseRst_pulses", n_phase - p0, ep);
        check("frameErr_pulses", n_ferr - f0, stop_ok ? 0 : 1);
        settling = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int n, input int v, input int g);
        check({tag, "_note"}, int'(note_o), n);
        check({tag, "_vel"}, int'(velocity_o), v);
        check({tag, "_gate"}, int'(gate_o), g);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, f0;
        logic [7:0] rb;

        model_reset();
        repeat (3) step();
        expect_out("reset", 8'h45 + 0 * 0 + 0, 0, 0);
        check("reset_phaseRst", int'(phaseRst_o), 0);
        check("reset_frameErr", int'(frameErr_o), 0);
        settling = 1'b0;
        repeat (4) step();
        nrst_i = 1'b1;
        repeat (8) step();

        // Note On, then running-status retrigger
        send_byte(8'h90, 1'b1); send_byte(8'h45, 1'b1); send_byte(8'h64, 1'b1);
        expect_out("on45", 8'h45, 8'h64, 1);
        send_byte(8'h40, 1'b1); send_byte(8'h50, 1'b1);
        expect_out("on40", 8'h40, 8'h50, 1);
        // Release of an older note is ignored; release of current note drops gate
        send_byte(8'h45, 1'b1); send_byte(8'h00, 1'b1);
        expect_out("off45", 8'h40, 8'h50, 1);
        send_byte(8'h40, 1'b1); send_byte(8'h00, 1'b1);
        expect_out("off40", 8'h40, 8'h50, 0);

        // Other channel is ignored
        send_byte(8'h91, 1'b1); send_byte(8'h30, 1'b1); send_byte(8'h7F, 1'b1);
        expect_out("wrongch", 8'h40, 8'h50, 0);

        // Clock byte interleaved, plus a framing-error byte that must vanish
        send_byte(8'h90, 1'b1); send_byte(8'h30, 1'b1); send_byte(8'hF8, 1'b1);
        send_byte(8'h35, 1'b0);
        send_byte(8'h7F, 1'b1);
        expect_out("rt_ferr", 8'h30, 8'h7F, 1);

        // Short low glitch: no byte, no framing error
        p0 = n_phase;
        f0 = n_ferr;
        rx_i = 1'b0;
        repeat (100) step();
        rx_i = 1'b1;
        repeat (300) step();
        check("glitch_phaseRst", n_phase - p0, 0);
        check("glitch_frameErr", n_ferr - f0, 0);

        // Reset while the velocity byte is in flight
        send_byte(8'h90, 1'b1); send_byte(8'h45, 1'b1);
        p0 = n_phase;
        rx_i = 1'b0;
        repeat (DIV * 3) step();
        nrst_i = 1'b0;
        model_reset();
        step();
        expect_out("midreset", 8'd69, 0, 0);
        rx_i = 1'b1;
        repeat (4) step();
        nrst_i = 1'b1;
        repeat (8) step();
        check("midreset_phaseRst", n_phase - p0, 0);
        send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h40, 1'b1);
        expect_out("after_reset", 8'h3C, 8'h40, 1);

        // Randomized tail: one status byte and two data bytes
        case ($urandom_range(0, 3))
            0: rb = {4'h9, CHANNEL};
            1: rb = {4'h8, CHANNEL};
            2: rb = {4'h9, 4'($urandom_range(1, 15))};
            default: rb = {4'hF, 4'($urandom_range(0, 15))};
        endcase
        send_byte(rb, 1'b1);
        for (int k = 0; k < 2; k++) begin
            rb = {1'b0, 7'($urandom_range(0, 127))};
            if ($urandom_range(0, 3) == 0 && k == 1) rb = 8'h00;
            send_byte(rb, 1'b1);
        end
        repeat (16) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
